// File: rtl/yarvi_mem_arb_if.sv
// Bundle of the core, ext and memory-side signals around the data-memory arbiter.
// slave  : the arbiter's view (drives stall/ready/rvalid/rdata and the memory request).
// master : the environment's view (core, ext requester and the memory itself).
interface yarvi_mem_arb_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    // core (ME stage) side
    logic              core_req;
    logic [DW/8-1:0]   core_wmask;
    logic [AW-1:0]     core_addr;
    logic [DW-1:0]     core_wdata;
    logic              core_stall;
    logic              core_rvalid;
    logic [DW-1:0]     core_rdata;
    // external loader/debug side
    logic              ext_valid;
    logic              ext_lock;
    logic [DW/8-1:0]   ext_wmask;
    logic [AW-1:0]     ext_addr;
    logic [DW-1:0]     ext_wdata;
    logic              ext_ready;
    logic              ext_rvalid;
    logic [DW-1:0]     ext_rdata;
    logic              ext_lock_lost;
    // memory side
    logic              mem_en;
    logic [DW/8-1:0]   mem_wmask;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  core_req, core_wmask, core_addr, core_wdata,
        output core_stall, core_rvalid, core_rdata,
        input  ext_valid, ext_lock, ext_wmask, ext_addr, ext_wdata,
        output ext_ready, ext_rvalid, ext_rdata, ext_lock_lost,
        output mem_en, mem_wmask, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_wmask, core_addr, core_wdata,
        input  core_stall, core_rvalid, core_rdata,
        output ext_valid, ext_lock, ext_wmask, ext_addr, ext_wdata,
        input  ext_ready, ext_rvalid, ext_rdata, ext_lock_lost,
        input  mem_en, mem_wmask, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/yarvi_mem_arb.sv
// Single-port data-memory arbiter: the core has priority, the ext port gets a
// grant after at most MAX_WAIT contended cycles, and ext may lock the port for
// read-modify-write sequences (bounded by LOCK_MAX cycles).
module yarvi_mem_arb #(
    parameter int AW       = 30,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic             clock,
    input  logic             reset,
    yarvi_mem_arb_if.slave   bus
);
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int LW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX);
    localparam logic [WW-1:0] WAIT_SAT  = WW'(MAX_WAIT);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_MAX - 1);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [WW-1:0]   wait_cnt_r;
    logic [LW-1:0]   lock_cnt_r;
    logic            core_rvalid_r;
    logic            ext_rvalid_r;
    logic            lock_lost_r;

    logic            starve_s;
    logic            grant_ext_s;
    logic            grant_core_s;
    logic            core_stall_s;
    logic            release_s;
    logic            timeout_s;
    logic            lost_set_s;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_OPEN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: enter LOCKED on a granted locked beat, leave on an
    // unlocked beat or when the lock has been held for LOCK_MAX cycles.
    always_comb begin
        state_nxt_s = state_r;
        lost_set_s  = 1'b0;
        case (state_r)
            ST_OPEN: begin
                if (grant_ext_s && bus.ext_lock) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_OPEN;
                end
            end
            ST_LOCKED: begin
                if (release_s) begin
                    state_nxt_s = ST_OPEN;
                end else if (timeout_s) begin
                    state_nxt_s = ST_OPEN;
                    lost_set_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_OPEN;
            end
        endcase
    end

    // Output logic: grant decision, stall/ready and the memory request mux.
    always_comb begin
        starve_s    = (wait_cnt_r == WAIT_SAT);
        release_s   = 1'b0;
        timeout_s   = (lock_cnt_r == LOCK_LAST);
        case (state_r)
            ST_OPEN: begin
                grant_ext_s  = bus.ext_valid & (~bus.core_req | starve_s);
                core_stall_s = bus.core_req & grant_ext_s;
            end
            ST_LOCKED: begin
                grant_ext_s  = bus.ext_valid;
                core_stall_s = bus.core_req;
                release_s    = grant_ext_s & ~bus.ext_lock;
            end
            default: begin
                grant_ext_s  = 1'b0;
                core_stall_s = bus.core_req;
            end
        endcase
        grant_core_s   = bus.core_req & ~core_stall_s;
        bus.ext_ready  = grant_ext_s;
        bus.core_stall = core_stall_s;
        if (grant_ext_s) begin
            bus.mem_en    = 1'b1;
            bus.mem_wmask = bus.ext_wmask;
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
        end else if (grant_core_s) begin
            bus.mem_en    = 1'b1;
            bus.mem_wmask = bus.core_wmask;
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
        end else begin
            bus.mem_en    = 1'b0;
            bus.mem_wmask = '0;
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
        end
    end

    // Starvation and lock-age counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_r <= '0;
            lock_cnt_r <= '0;
        end else begin
            if (state_r == ST_LOCKED) begin
                wait_cnt_r <= wait_cnt_r;
            end else if (grant_ext_s || !bus.ext_valid) begin
                wait_cnt_r <= '0;
            end else if (bus.core_req && !starve_s) begin
                wait_cnt_r <= wait_cnt_r + WW'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (state_r == ST_LOCKED && state_nxt_s == ST_LOCKED) begin
                lock_cnt_r <= lock_cnt_r + LW'(1);
            end else begin
                lock_cnt_r <= '0;
            end
        end
    end

    // Registered response flags: one owner per granted read, so returns stay in order.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_rvalid_r <= 1'b0;
            ext_rvalid_r  <= 1'b0;
            lock_lost_r   <= 1'b0;
        end else begin
            core_rvalid_r <= grant_core_s & (bus.core_wmask == '0);
            ext_rvalid_r  <= grant_ext_s & (bus.ext_wmask == '0);
            lock_lost_r   <= lost_set_s;
        end
    end

    assign bus.core_rvalid   = core_rvalid_r;
    assign bus.ext_rvalid    = ext_rvalid_r;
    assign bus.ext_lock_lost = lock_lost_r;
    assign bus.core_rdata    = bus.mem_rdata;
    assign bus.ext_rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_yarvi_mem_arb.sv
// Directed bench for yarvi_mem_arb with a behavioural reference model checked every cycle.
module tb_yarvi_mem_arb;
    localparam int MAX_WAIT = 8;
    localparam int LOCK_MAX = 16;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    yarvi_mem_arb_if #(.AW(30), .DW(32)) bus ();

    yarvi_mem_arb #(.AW(30), .DW(32), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory attached to the DUT, and the model's private copy
    logic [31:0] mem  [256];
    logic [31:0] mmem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'h01010101 * i;
            mmem[i] = 32'h01010101 * i;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wmask == 4'h0) begin
                bus.mem_rdata <= mem[bus.mem_addr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wmask[b]) mem[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port this cycle, and what the outputs must be.
    initial begin : model
        bit          armed = 1'b0;
        int          waited = 0;
        bit          locked = 1'b0;
        int          lock_age = 0;
        bit          exp_lost = 1'b0;
        bit          exp_crv = 1'b0, exp_erv = 1'b0;
        logic [31:0] exp_crd = '0, exp_erd = '0;
        bit          g_ext, g_core, stall;
        bit          s_req, s_ev, s_lock;
        logic [3:0]  s_cm, s_em;
        logic [29:0] s_ca, s_ea;
        logic [31:0] s_cd, s_ed;
        forever begin
            @(negedge clk);
            s_req = bus.core_req;  s_cm = bus.core_wmask; s_ca = bus.core_addr; s_cd = bus.core_wdata;
            s_ev  = bus.ext_valid; s_lock = bus.ext_lock; s_em = bus.ext_wmask;
            s_ea  = bus.ext_addr;  s_ed = bus.ext_wdata;
            g_ext  = s_ev && (locked || !s_req || waited >= MAX_WAIT);
            g_core = s_req && !locked && !g_ext;
            stall  = s_req && !g_core;
            if (armed && !rst) begin
                chk("ext_ready", bus.ext_ready, g_ext);
                chk("core_stall", bus.core_stall, stall);
                chk("mem_en", bus.mem_en, g_ext || g_core);
                if (g_ext) begin
                    chk("mem_addr", bus.mem_addr, s_ea);
                    chk("mem_wmask", bus.mem_wmask, s_em);
                    chk("mem_wdata", bus.mem_wdata, s_ed);
                end else if (g_core) begin
                    chk("mem_addr", bus.mem_addr, s_ca);
                    chk("mem_wmask", bus.mem_wmask, s_cm);
                    chk("mem_wdata", bus.mem_wdata, s_cd);
                end
                chk("core_rvalid", bus.core_rvalid, exp_crv);
                chk("ext_rvalid", bus.ext_rvalid, exp_erv);
                chk("ext_lock_lost", bus.ext_lock_lost, exp_lost);
                if (exp_crv) chk("core_rdata", bus.core_rdata, exp_crd);
                if (exp_erv) chk("ext_rdata", bus.ext_rdata, exp_erd);
            end
            @(posedge clk);
            if (rst) begin
                armed = 1'b1; waited = 0; locked = 1'b0; lock_age = 0;
                exp_lost = 1'b0; exp_crv = 1'b0; exp_erv = 1'b0;
            end else if (armed) begin
                exp_crv = g_core && s_cm == 4'h0;
                exp_erv = g_ext && s_em == 4'h0;
                if (g_core) exp_crd = mmem[s_ca[7:0]];
                if (g_ext)  exp_erd = mmem[s_ea[7:0]];
                for (int b = 0; b < 4; b++) begin
                    if (g_core && s_cm[b]) mmem[s_ca[7:0]][8*b +: 8] = s_cd[8*b +: 8];
                    if (g_ext && s_em[b])  mmem[s_ea[7:0]][8*b +: 8] = s_ed[8*b +: 8];
                end
                exp_lost = 1'b0;
                if (locked) begin
                    if (g_ext && !s_lock) begin
                        locked = 1'b0;
                    end else if (lock_age == LOCK_MAX - 1) begin
                        locked = 1'b0; exp_lost = 1'b1;
                    end else begin
                        lock_age++;
                    end
                end else begin
                    if (g_ext && s_lock) begin
                        locked = 1'b1; lock_age = 0;
                    end
                    if (g_ext || !s_ev) waited = 0;
                    else if (s_req && waited < MAX_WAIT) waited++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.core_req = 1'b0; bus.core_wmask = 4'h0; bus.core_addr = 30'h0; bus.core_wdata = 32'h0;
        bus.ext_valid = 1'b0; bus.ext_lock = 1'b0; bus.ext_wmask = 4'h0;
        bus.ext_addr = 30'h0; bus.ext_wdata = 32'h0;
    endtask

    task automatic core_rd(input logic [29:0] a);
        bus.core_req = 1'b1; bus.core_wmask = 4'h0; bus.core_addr = a;
    endtask

    task automatic ext_acc(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d, input logic l);
        bus.ext_valid = 1'b1; bus.ext_lock = l; bus.ext_wmask = m; bus.ext_addr = a; bus.ext_wdata = d;
    endtask

    // Directed stimulus with hand-computed literal expectations.
    initial begin : stim
        bit acc;
        rst = 1'b1;
        idle();
        cyc(); cyc();
        rst = 1'b0;
        // out of reset: core request goes straight through
        core_rd(30'h5);
        #3;
        chk("rst_core_stall", bus.core_stall, 1'b0);
        chk("rst_core_rvalid", bus.core_rvalid, 1'b0);
        chk("rst_ext_rvalid", bus.ext_rvalid, 1'b0);
        chk("rst_lock_lost", bus.ext_lock_lost, 1'b0);

        // core read 0x10
        cyc(); idle(); core_rd(30'h10);
        #3;
        chk("t1_mem_en", bus.mem_en, 1'b1);
        chk("t1_mem_addr", bus.mem_addr, 30'h10);
        cyc(); idle();
        #3;
        chk("t1_core_rvalid", bus.core_rvalid, 1'b1);
        chk("t1_core_rdata", bus.core_rdata, 32'h10101010);

        // ext write 0x20, then read it back
        cyc(); idle(); ext_acc(30'h20, 4'hF, 32'hDEADBEEF, 1'b0);
        #3;
        chk("t2_ext_ready", bus.ext_ready, 1'b1);
        chk("t2_mem_wmask", bus.mem_wmask, 4'hF);
        cyc(); idle(); ext_acc(30'h20, 4'h0, 32'h0, 1'b0);
        cyc(); idle();
        #3;
        chk("t2_ext_rdata", bus.ext_rdata, 32'hDEADBEEF);

        // starvation bound: ext granted at cycle 8 only
        acc = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(); idle(); core_rd(30'h22);
            if (!acc) ext_acc(30'h21, 4'h0, 32'h0, 1'b0);
            #3;
            chk("t3_ext_ready", bus.ext_ready, (i == 8));
            chk("t3_core_stall", bus.core_stall, (i == 8));
            if (i == 9) chk("t3_ext_rdata", bus.ext_rdata, 32'h21212121);
            if (bus.ext_ready) acc = 1'b1;
        end
        cyc(); idle();

        // locked read-modify-write while the core keeps requesting
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            cyc(); idle(); core_rd(30'h30); ext_acc(30'h30, 4'h0, 32'h0, 1'b1);
            #3;
            if (bus.ext_ready) acc = 1'b1;
        end
        chk("t4_lock_acc", acc, 1'b1);
        chk("t4_stall0", bus.core_stall, 1'b1);
        cyc(); idle(); core_rd(30'h30);
        #3;
        chk("t4_stall1", bus.core_stall, 1'b1);
        chk("t4_rdata", bus.ext_rdata, 32'h30303030);
        cyc(); idle(); core_rd(30'h30); ext_acc(30'h30, 4'h3, 32'h12345678, 1'b0);
        #3;
        chk("t4_wr_ready", bus.ext_ready, 1'b1);
        chk("t4_stall2", bus.core_stall, 1'b1);
        cyc(); idle(); core_rd(30'h30);
        #3;
        chk("t4_core_granted", bus.core_stall, 1'b0);
        cyc(); idle();
        #3;
        chk("t4_core_rdata", bus.core_rdata, 32'h30305678);

        // lock timeout
        cyc(); idle(); ext_acc(30'h40, 4'h0, 32'h0, 1'b1);
        #3;
        chk("t5_lock_ready", bus.ext_ready, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            cyc(); idle(); core_rd(30'h41);
            #3;
            chk("t5_stall", bus.core_stall, (k < 17));
            chk("t5_lock_lost", bus.ext_lock_lost, (k == 17));
        end

        // reset while locked with an ext read in flight
        cyc(); idle(); ext_acc(30'h50, 4'h0, 32'h0, 1'b1);
        cyc(); idle(); ext_acc(30'h51, 4'h0, 32'h0, 1'b1); rst = 1'b1;
        #3;
        chk("t6_locked_ready", bus.ext_ready, 1'b1);
        cyc(); idle(); rst = 1'b0; core_rd(30'h52);
        #3;
        chk("t6_core_stall", bus.core_stall, 1'b0);
        chk("t6_ext_rvalid", bus.ext_rvalid, 1'b0);
        chk("t6_lock_lost", bus.ext_lock_lost, 1'b0);

        // alternating owners back to back
        cyc(); idle(); core_rd(30'h11);
        cyc(); idle(); ext_acc(30'h12, 4'h0, 32'h0, 1'b0);
        #3;
        chk("t7_core_rdata", bus.core_rdata, 32'h11111111);
        cyc(); idle();
        #3;
        chk("t7_ext_rvalid", bus.ext_rvalid, 1'b1);
        chk("t7_core_rvalid", bus.core_rvalid, 1'b0);
        chk("t7_ext_rdata", bus.ext_rdata, 32'h12121212);
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
